// File: rtl/alu_branch_ctrl.sv
// rtl/alu_branch_ctrl.sv - branch resolution sequencer driving the ALU compare (optional BRANCH_UNSIGNED_EN)
// Accepts branch/jump requests, issues SUB to the ALU, evaluates the condition and returns the next PC.
module alu_branch_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic [4:0]            Req_Op,
  input  logic [DATA_WIDTH-1:0] Req_Rs1,
  input  logic [DATA_WIDTH-1:0] Req_Rs2,
  input  logic [ADDR_WIDTH-1:0] Req_PC,
  input  logic [ADDR_WIDTH-1:0] Req_Offset,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [4:0]            ALU_Sel,
  input  logic [DATA_WIDTH-1:0] ALU_Out,
  input  logic                  CarryOut,
  input  logic                  Zero,
  input  logic                  Overflow,
  input  logic                  Negative,
  output logic                  Resp_Valid,
  input  logic                  Resp_Ready,
  output logic                  Resp_Taken,
  output logic [ADDR_WIDTH-1:0] Resp_NextPC,
  output logic                  Resp_Illegal,
  output logic [3:0]            Flags_Q
);

  localparam logic [4:0] OP_JUMP  = 5'b10010;
  localparam logic [4:0] OP_BEQ   = 5'b10011;
  localparam logic [4:0] OP_BNE   = 5'b10100;
  localparam logic [4:0] OP_BLT   = 5'b10101;
  localparam logic [4:0] OP_BGT   = 5'b10110;
  localparam logic [4:0] OP_BGE   = 5'b10111;
  localparam logic [4:0] OP_BLE   = 5'b11000;
  localparam logic [4:0] OP_BLTU  = 5'b11001;
  localparam logic [4:0] OP_BGEU  = 5'b11010;
  localparam logic [4:0] SEL_SUB  = 5'b00001;
  localparam logic [4:0] SEL_PASS = 5'b01111;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESOLVE, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              op_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   off_q;
  logic                    taken;
  logic                    illegal;
  logic                    lt;
  logic                    unused_alu_out;

  assign unused_alu_out = ^ALU_Out;

  function automatic logic is_cmp(input logic [4:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGT, OP_BGE, OP_BLE: is_cmp = 1'b1;
`ifdef BRANCH_UNSIGNED_EN
      OP_BLTU, OP_BGEU: is_cmp = 1'b1;
`endif
      default: is_cmp = 1'b0;
    endcase
  endfunction

  assign Req_Ready = (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Req_Valid) state_d = is_cmp(Req_Op) ? S_ISSUE : S_RESOLVE;
      S_ISSUE:   state_d = S_RESOLVE;
      S_RESOLVE: state_d = S_RESP;
      S_RESP:    if (Resp_Ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Flags_Q is {C,Z,V,N}; signed less-than is N^V after SUB.
  always_comb begin
    lt      = Flags_Q[1] ^ Flags_Q[0];
    taken   = 1'b0;
    illegal = 1'b0;
    case (op_q)
      OP_JUMP: taken = 1'b1;
      OP_BEQ:  taken = Flags_Q[2];
      OP_BNE:  taken = !Flags_Q[2];
      OP_BLT:  taken = lt;
      OP_BGE:  taken = !lt;
      OP_BGT:  taken = !Flags_Q[2] && !lt;
      OP_BLE:  taken = Flags_Q[2] || lt;
`ifdef BRANCH_UNSIGNED_EN
      OP_BLTU: taken = Flags_Q[3];
      OP_BGEU: taken = !Flags_Q[3];
`endif
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      pc_q         <= '0;
      off_q        <= '0;
      ALU_A        <= '0;
      ALU_B        <= '0;
      ALU_Sel      <= SEL_PASS;
      Flags_Q      <= '0;
      Resp_Valid   <= 1'b0;
      Resp_Taken   <= 1'b0;
      Resp_Illegal <= 1'b0;
      Resp_NextPC  <= '0;
    end else begin
      // ALU operands are only non-idle during the single ISSUE cycle.
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_Sel <= SEL_PASS;
      case (state_q)
        S_IDLE: begin
          if (Req_Valid) begin
            op_q  <= Req_Op;
            pc_q  <= Req_PC;
            off_q <= Req_Offset;
            if (is_cmp(Req_Op)) begin
              ALU_A   <= Req_Rs1;
              ALU_B   <= Req_Rs2;
              ALU_Sel <= SEL_SUB;
            end
          end
        end
        S_ISSUE: Flags_Q <= {CarryOut, Zero, Overflow, Negative};
        S_RESOLVE: begin
          Resp_Taken   <= taken;
          Resp_Illegal <= illegal;
          Resp_NextPC  <= taken ? (pc_q + off_q) : (pc_q + ADDR_WIDTH'(4));
          Resp_Valid   <= 1'b1;
        end
        S_RESP: if (Resp_Ready) Resp_Valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_branch_ctrl.sv
// tb/tb_alu_branch_ctrl.sv - directed self-checking bench for alu_branch_ctrl
module tb_alu_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic [4:0]  Req_Op = '0;
  logic [31:0] Req_Rs1 = '0, Req_Rs2 = '0, Req_PC = '0, Req_Offset = '0;
  logic [31:0] ALU_A, ALU_B, ALU_Out;
  logic [4:0]  ALU_Sel;
  logic        CarryOut, Zero, Overflow, Negative;
  logic        Resp_Valid;
  logic        Resp_Ready = 1'b0;
  logic        Resp_Taken;
  logic [31:0] Resp_NextPC;
  logic        Resp_Illegal;
  logic [3:0]  Flags_Q;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: SUB and pass-A with borrow-style carry.
  logic [31:0] diff;
  always_comb begin
    diff = ALU_A - ALU_B;
    if (ALU_Sel == 5'b00001) begin
      ALU_Out  = diff;
      CarryOut = (ALU_A < ALU_B);
      Overflow = (ALU_A[31] != ALU_B[31]) && (diff[31] != ALU_A[31]);
    end else begin
      ALU_Out  = ALU_A;
      CarryOut = 1'b0;
      Overflow = 1'b0;
    end
    Zero     = (ALU_Out == 32'd0);
    Negative = ALU_Out[31];
  end

  alu_branch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Op(Req_Op),
    .Req_Rs1(Req_Rs1), .Req_Rs2(Req_Rs2), .Req_PC(Req_PC), .Req_Offset(Req_Offset),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out),
    .CarryOut(CarryOut), .Zero(Zero), .Overflow(Overflow), .Negative(Negative),
    .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_Taken(Resp_Taken),
    .Resp_NextPC(Resp_NextPC), .Resp_Illegal(Resp_Illegal), .Flags_Q(Flags_Q)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] off);
    Req_Op = op; Req_Rs1 = a; Req_Rs2 = b; Req_PC = pc; Req_Offset = off;
    Req_Valid = 1'b1;
    checks++;
    if (Req_Ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready got=%b want=1", Req_Ready);
    end
    step();
    Req_Valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic do_branch(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc, input logic [31:0] off,
                           input logic [4:0] exp_sel, input int exp_lat, input logic exp_taken,
                           input logic [31:0] exp_pc, input logic exp_ill, input logic [3:0] exp_flags);
    int lat;
    send(op, a, b, pc, off);
    checks++;
    if (ALU_Sel !== exp_sel) begin
      failures++;
      $display("FAIL %s alu_sel_c1 got=%b want=%b", name, ALU_Sel, exp_sel);
    end
    lat = 1;
    while (Resp_Valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
    end
    checks++;
    if (Resp_Taken !== exp_taken) begin
      failures++;
      $display("FAIL %s taken got=%b want=%b", name, Resp_Taken, exp_taken);
    end
    checks++;
    if (Resp_NextPC !== exp_pc) begin
      failures++;
      $display("FAIL %s next_pc got=%h want=%h", name, Resp_NextPC, exp_pc);
    end
    checks++;
    if (Resp_Illegal !== exp_ill) begin
      failures++;
      $display("FAIL %s illegal got=%b want=%b", name, Resp_Illegal, exp_ill);
    end
    checks++;
    if (Flags_Q !== exp_flags) begin
      failures++;
      $display("FAIL %s flags got=%b want=%b", name, Flags_Q, exp_flags);
    end
    Resp_Ready = 1'b1;
    step();
    Resp_Ready = 1'b0;
    checks++;
    if (Resp_Valid !== 1'b0 || Req_Ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release got_valid=%b got_ready=%b want 0/1", name, Resp_Valid, Req_Ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if (Req_Ready !== 1'b1 || Resp_Valid !== 1'b0 || Resp_Taken !== 1'b0 || Resp_Illegal !== 1'b0 ||
        Resp_NextPC !== 32'd0 || Flags_Q !== 4'd0 || ALU_A !== 32'd0 || ALU_B !== 32'd0 ||
        ALU_Sel !== 5'b01111) begin
      failures++;
      $display("FAIL reset_held rdy=%b val=%b tk=%b ill=%b pc=%h fl=%b a=%h b=%h sel=%b want 1/0/0/0/0/0/0/0/01111",
               Req_Ready, Resp_Valid, Resp_Taken, Resp_Illegal, Resp_NextPC, Flags_Q, ALU_A, ALU_B, ALU_Sel);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (Req_Ready !== 1'b1 || Resp_Valid !== 1'b0 || ALU_Sel !== 5'b01111) begin
      failures++;
      $display("FAIL reset_release rdy=%b val=%b sel=%b want 1/0/01111", Req_Ready, Resp_Valid, ALU_Sel);
    end
  endtask

  task automatic test_beq();
    do_branch("beq", 5'b10011, 32'h5, 32'h5, 32'h100, 32'h20, 5'b00001, 3, 1'b1, 32'h120, 1'b0, 4'b0100);
  endtask

  task automatic test_blt_bge();
    do_branch("blt", 5'b10101, 32'h80000000, 32'h1, 32'h200, 32'h40, 5'b00001, 3, 1'b1, 32'h240, 1'b0, 4'b0010);
    do_branch("bge", 5'b10111, 32'h80000000, 32'h1, 32'h200, 32'h40, 5'b00001, 3, 1'b0, 32'h204, 1'b0, 4'b0010);
  endtask

  task automatic test_jump();
    do_branch("jump", 5'b10010, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h20, 5'b01111, 2, 1'b1, 32'h10, 1'b0, 4'b0010);
  endtask

  task automatic test_illegal();
    do_branch("illegal", 5'b00000, 32'h0, 32'h0, 32'h40, 32'h100, 5'b01111, 2, 1'b0, 32'h44, 1'b1, 4'b0010);
  endtask

  task automatic test_back_to_back();
    int a1;
    do_branch("b2b_beq", 5'b10011, 32'h1, 32'h2, 32'h500, 32'h80, 5'b00001, 3, 1'b0, 32'h504, 1'b0, 4'b1001);
    a1 = acc_cyc;
    do_branch("b2b_ble", 5'b11000, 32'h1, 32'h2, 32'h600, 32'h10, 5'b00001, 3, 1'b1, 32'h610, 1'b0, 4'b1001);
    checks++;
    if (acc_cyc - a1 !== 4) begin
      failures++;
      $display("FAIL b2b_cmp_interval got=%0d want=4", acc_cyc - a1);
    end
    do_branch("b2b_j1", 5'b10010, 32'h0, 32'h0, 32'h10, 32'h100, 5'b01111, 2, 1'b1, 32'h110, 1'b0, 4'b1001);
    a1 = acc_cyc;
    do_branch("b2b_j2", 5'b10010, 32'h0, 32'h0, 32'h20, 32'hFFFFFFFC, 5'b01111, 2, 1'b1, 32'h1C, 1'b0, 4'b1001);
    checks++;
    if (acc_cyc - a1 !== 3) begin
      failures++;
      $display("FAIL b2b_jump_interval got=%0d want=3", acc_cyc - a1);
    end
  endtask

  task automatic test_bltu();
`ifdef BRANCH_UNSIGNED_EN
    do_branch("bltu", 5'b11001, 32'h1, 32'hFFFFFFFF, 32'h700, 32'h30, 5'b00001, 3, 1'b1, 32'h730, 1'b0, 4'b1000);
`else
    do_branch("bltu", 5'b11001, 32'h1, 32'hFFFFFFFF, 32'h700, 32'h30, 5'b01111, 2, 1'b0, 32'h704, 1'b1, 4'b1001);
`endif
  endtask

  task automatic test_backpressure_reset();
    int lat;
    send(5'b10100, 32'h3, 32'h7, 32'h300, 32'h8);
    lat = 1;
    while (Resp_Valid !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL bp_latency got=%0d want=3", lat);
    end
    // Competing request while stalled must be ignored.
    Req_Valid = 1'b1; Req_Op = 5'b10010; Req_PC = 32'h900; Req_Offset = 32'h4;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (Resp_Valid !== 1'b1 || Resp_Taken !== 1'b1 || Resp_NextPC !== 32'h308 ||
          Resp_Illegal !== 1'b0 || Flags_Q !== 4'b1001 || Req_Ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] val=%b tk=%b pc=%h ill=%b fl=%b rdy=%b want 1/1/308/0/1001/0",
                 i, Resp_Valid, Resp_Taken, Resp_NextPC, Resp_Illegal, Flags_Q, Req_Ready);
      end
      step();
    end
    Resp_Ready = 1'b1;
    step();
    Resp_Ready = 1'b0;
    checks++;
    if (Resp_Valid !== 1'b0 || Req_Ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_no_accept_in_resp val=%b rdy=%b want 0/1", Resp_Valid, Req_Ready);
    end
    Req_Valid = 1'b0;
    step();
    send(5'b10100, 32'h5, 32'h5, 32'h400, 32'h8);
    checks++;
    if (ALU_Sel !== 5'b00001 || ALU_A !== 32'h5) begin
      failures++;
      $display("FAIL issue_before_reset sel=%b a=%h want 00001/5", ALU_Sel, ALU_A);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Req_Ready !== 1'b1 || Resp_Valid !== 1'b0 || Resp_Taken !== 1'b0 || Resp_Illegal !== 1'b0 ||
        Resp_NextPC !== 32'd0 || Flags_Q !== 4'd0 || ALU_A !== 32'd0 || ALU_B !== 32'd0 ||
        ALU_Sel !== 5'b01111) begin
      failures++;
      $display("FAIL async_reset rdy=%b val=%b tk=%b ill=%b pc=%h fl=%b a=%h b=%h sel=%b want 1/0/0/0/0/0/0/0/01111",
               Req_Ready, Resp_Valid, Resp_Taken, Resp_Illegal, Resp_NextPC, Flags_Q, ALU_A, ALU_B, ALU_Sel);
    end
    step();
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if (Resp_Valid !== 1'b0 || Req_Ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_discard val=%b rdy=%b want 0/1", Resp_Valid, Req_Ready);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blt_bge();
    test_jump();
    test_illegal();
    test_back_to_back();
    test_bltu();
    test_backpressure_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
